// File: rtl/mem_data_ctrl_pkg.sv
// Shared constants for the load/store data controller: instruction encodings,
// widths, IO address decode and small byte-lane helpers.
package mem_data_ctrl_pkg;

    localparam int INST_TYPE_WIDTH = 4;
    localparam int DATA_WIDTH      = 32;

    localparam logic [INST_TYPE_WIDTH-1:0] OT_LB  = 4'd0;
    localparam logic [INST_TYPE_WIDTH-1:0] OT_LH  = 4'd1;
    localparam logic [INST_TYPE_WIDTH-1:0] OT_LW  = 4'd2;
    localparam logic [INST_TYPE_WIDTH-1:0] OT_LBU = 4'd3;
    localparam logic [INST_TYPE_WIDTH-1:0] OT_LHU = 4'd4;
    localparam logic [INST_TYPE_WIDTH-1:0] OT_SB  = 4'd5;
    localparam logic [INST_TYPE_WIDTH-1:0] OT_SH  = 4'd6;
    localparam logic [INST_TYPE_WIDTH-1:0] OT_SW  = 4'd7;

    // addr[17:16] selecting the UART/IO window
    localparam logic [1:0] IO_SPACE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic is_io(input logic [DATA_WIDTH-1:0] a);
        return (a[17:16] == IO_SPACE);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] byte_addr(input logic [DATA_WIDTH-1:0] base,
                                                        input logic [2:0] k);
        return base + {29'd0, k};
    endfunction

    function automatic logic [7:0] byte_sel(input logic [DATA_WIDTH-1:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_size_decode.sv
// Maps an ordertype to its access size in bytes and its direction.
module mem_size_decode
    import mem_data_ctrl_pkg::*;
(
    input  logic [INST_TYPE_WIDTH-1:0] ordertype,
    output logic [2:0]                 n_bytes,
    output logic                       is_store
);

    // Size/direction table
    always_comb begin
        n_bytes  = 3'd1;
        is_store = 1'b0;
        case (ordertype)
            OT_LB, OT_LBU: n_bytes = 3'd1;
            OT_LH, OT_LHU: n_bytes = 3'd2;
            OT_LW:         n_bytes = 3'd4;
            OT_SB: begin n_bytes = 3'd1; is_store = 1'b1; end
            OT_SH: begin n_bytes = 3'd2; is_store = 1'b1; end
            OT_SW: begin n_bytes = 3'd4; is_store = 1'b1; end
            default: begin n_bytes = 3'd1; is_store = 1'b0; end
        endcase
    end

endmodule

// File: rtl/mem_data_ctrl.sv
// Byte-serial load/store controller between the load/store buffer and a
// byte-wide synchronous RAM (one cycle read latency) with IO backpressure.
module mem_data_ctrl
    import mem_data_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       clear,
    input  logic                       load_req,
    input  logic                       store_req,
    input  logic [INST_TYPE_WIDTH-1:0] ordertype,
    input  logic [DATA_WIDTH-1:0]      vj,
    input  logic [DATA_WIDTH-1:0]      vk,
    input  logic [DATA_WIDTH-1:0]      A,
    output logic                       data_ok,
    output logic [DATA_WIDTH-1:0]      data_ans,
    output logic                       busy,
    input  logic [7:0]                 mem_din,
    output logic [7:0]                 mem_dout,
    output logic [DATA_WIDTH-1:0]      mem_a,
    output logic                       mem_wr,
    input  logic                       io_buffer_full
);

    state_t                state_r, state_s;
    logic [DATA_WIDTH-1:0] addr_r, vk_r, addr_s;
    logic [2:0]            n_r, issue_r, cap_r, n_s, cap_n_s, issue_inc_s;
    logic                  pend_r, store_r, io_r;
    logic                  is_store_s, op_store_s, accept_s, stall_s, write_s, last_s;

    mem_size_decode u_size_decode (
        .ordertype (ordertype),
        .n_bytes   (n_s),
        .is_store  (is_store_s)
    );

    // A strobe names the direction; store wins a tie
    assign op_store_s  = store_req ? 1'b1 : (is_store_s & ~load_req);
    assign addr_s      = vj + A;
    assign accept_s    = (state_r == IDLE) & rdy & ~clear & (load_req | store_req);
    assign stall_s     = io_r & io_buffer_full;
    assign write_s     = (state_r == STORE) & rdy & ~stall_s & ~rst;
    assign last_s      = (issue_r == (n_r - 3'd1));
    assign cap_n_s     = cap_r + {2'b00, pend_r};
    assign issue_inc_s = issue_r + 3'd1;
    assign busy        = (state_r != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Next state, write strobe and completion pulse
    always_comb begin
        state_s = state_r;
        mem_wr  = 1'b0;
        data_ok = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = op_store_s ? STORE : LOAD;
                else          state_s = IDLE;
            end
            LOAD: begin
                if (!rdy)                     state_s = LOAD;
                else if (clear)               state_s = IDLE;
                else if (cap_n_s == n_r)      state_s = DONE;
                else                          state_s = LOAD;
            end
            STORE: begin
                mem_wr = write_s;
                if (write_s && last_s) state_s = DONE;
                else                   state_s = STORE;
            end
            DONE: begin
                if (!rdy)                   state_s = DONE;
                else if (clear && !store_r) state_s = IDLE;
                else begin
                    data_ok = ~rst;
                    state_s = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Request latch, address sequencing and byte assembly.
    // issue_r: byte index on mem_a now; pend_r: mem_din holds byte cap_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r   <= 32'd0;
            vk_r     <= 32'd0;
            n_r      <= 3'd0;
            store_r  <= 1'b0;
            io_r     <= 1'b0;
            issue_r  <= 3'd0;
            cap_r    <= 3'd0;
            pend_r   <= 1'b0;
            mem_a    <= 32'd0;
            mem_dout <= 8'd0;
            data_ans <= 32'd0;
        end else if (accept_s) begin
            addr_r  <= addr_s;
            vk_r    <= vk;
            n_r     <= n_s;
            store_r <= op_store_s;
            io_r    <= is_io(addr_s);
            issue_r <= 3'd0;
            cap_r   <= 3'd0;
            pend_r  <= 1'b0;
            mem_a   <= addr_s;
            if (op_store_s) mem_dout <= vk[7:0];
            else            data_ans <= 32'd0;
        end else if (state_r == LOAD && rdy && !clear) begin
            if (pend_r) data_ans[{cap_r[1:0], 3'b000} +: 8] <= mem_din;
            cap_r <= cap_n_s;
            if (issue_r == cap_n_s) begin
                pend_r  <= 1'b1;
                issue_r <= issue_inc_s;
                if (issue_inc_s < n_r) mem_a <= byte_addr(addr_r, issue_inc_s);
            end else begin
                // After a stall the RAM output is stale; re-present the awaited byte
                pend_r  <= 1'b0;
                issue_r <= cap_n_s;
                mem_a   <= byte_addr(addr_r, cap_n_s);
            end
        end else if (state_r == LOAD && !rdy) begin
            pend_r <= (issue_r == cap_r);
        end else if (write_s && !last_s) begin
            issue_r  <= issue_inc_s;
            mem_a    <= byte_addr(addr_r, issue_inc_s);
            mem_dout <= byte_sel(vk_r, issue_inc_s[1:0]);
        end
    end

endmodule
